// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, flag bit positions, writeback FSM states and defaults
package alu_pkg;

    typedef enum logic [3:0] {
        FN_ADD = 4'b0000,
        FN_ADC = 4'b0001,
        FN_SUB = 4'b0010,
        FN_SBC = 4'b0011,
        FN_MUL = 4'b0100,
        FN_MLL = 4'b0101,
        FN_RAS = 4'b0111,
        FN_LSH = 4'b1000,
        FN_RSH = 4'b1001,
        FN_LRT = 4'b1010,
        FN_RRT = 4'b1011,
        FN_AND = 4'b1100,
        FN_OR  = 4'b1101,
        FN_XOR = 4'b1110,
        FN_NOT = 4'b1111
    } func_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam int A_REG_DEFAULT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR_Y = 2'd1,
        ST_WR_A = 2'd2
    } wb_state_e;

endpackage

// File: rtl/alu_writeback.sv
// alu_writeback: latches an ALU result and sequences register-file writes (two for MUL), owns the flags register
//   in_valid/in_ready            : upstream handshake; accept = in_valid && in_ready
//   in_func/in_y/in_to_a         : ALU function code, result and MUL high half
//   in_flags/in_flags_we/in_dest : {C,N,Z,V}, flag update enable, destination register
//   rf_we/rf_waddr/rf_wdata      : register-file write request, held stable until rf_ready
//   flags                        : architectural flags {C,N,Z,V}
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int A_REG  = A_REG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_func,
    input  logic [DATA_W-1:0] in_y,
    input  logic [DATA_W-1:0] in_to_a,
    input  logic [3:0]        in_flags,
    input  logic              in_flags_we,
    input  logic [REG_AW-1:0] in_dest,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ready,
    output logic [3:0]        flags
);

    wb_state_e         state_q, state_d;
    logic [3:0]        func_q, func_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] to_a_q, to_a_d;
    logic [3:0]        nflags_q, nflags_d;
    logic              flags_we_q, flags_we_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [3:0]        flags_q, flags_d;
    logic              accept, commit, dual;

    // Outputs decode straight from the state register, so an async reset drops rf_we at once
    assign dual     = func_q == FN_MUL;
    assign rf_we    = state_q != ST_IDLE;
    assign rf_waddr = state_q == ST_WR_A ? REG_AW'(A_REG) : state_q == ST_WR_Y ? dest_q : '0;
    assign rf_wdata = state_q == ST_WR_A ? to_a_q : state_q == ST_WR_Y ? y_q : '0;
    assign flags    = flags_q;
    assign commit   = rf_we && rf_ready;
    // A MUL in WR_Y still owes its A write, so it cannot take a new op even on commit
    assign in_ready = state_q == ST_IDLE || (state_q == ST_WR_Y && !dual && rf_ready) ||
                      (state_q == ST_WR_A && rf_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        func_d     = accept ? in_func : func_q;
        y_d        = accept ? in_y : y_q;
        to_a_d     = accept ? in_to_a : to_a_q;
        nflags_d   = accept ? in_flags : nflags_q;
        flags_we_d = accept ? in_flags_we : flags_we_q;
        dest_d     = accept ? in_dest : dest_q;
        // Flags commit with the Y write, using the operands latched before any same-edge accept
        flags_d    = (state_q == ST_WR_Y && commit && flags_we_q) ? nflags_q : flags_q;
        case (state_q)
            ST_IDLE: state_d = accept ? ST_WR_Y : ST_IDLE;
            ST_WR_Y: state_d = !commit ? ST_WR_Y : dual ? ST_WR_A : accept ? ST_WR_Y : ST_IDLE;
            ST_WR_A: state_d = !commit ? ST_WR_A : accept ? ST_WR_Y : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            func_q     <= '0;
            y_q        <= '0;
            to_a_q     <= '0;
            nflags_q   <= '0;
            flags_we_q <= 1'b0;
            dest_q     <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            func_q     <= func_d;
            y_q        <= y_d;
            to_a_q     <= to_a_d;
            nflags_q   <= nflags_d;
            flags_we_q <= flags_we_d;
            dest_q     <= dest_d;
            flags_q    <= flags_d;
        end
    end

endmodule
